// File: rtl/console_pkg.sv
// Shared geometry, control codes and state encoding for the text console writer.
// The address calculator is shift-add specific to a 40-column screen.
package console_pkg;

  localparam int COLS   = 40;
  localparam int ROWS   = 32;
  localparam int ADDR_W = 11;
  localparam int COL_W  = 6;
  localparam int ROW_W  = 5;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    CLEAR_LINE
  } console_state_t;

endpackage

// File: rtl/console_addr_calc.sv
// Row/column to linear character RAM address: row*40 + col as (row<<5)+(row<<3)+col.
module console_addr_calc
  import console_pkg::*;
(
  input  logic [COL_W-1:0]  col,
  input  logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] row_w;
  logic [ADDR_W-1:0] col_w;

  assign row_w = ADDR_W'(row);
  assign col_w = ADDR_W'(col);
  assign addr  = (row_w << 5) + (row_w << 3) + col_w;

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream to character RAM writer for a 40x32 text terminal: cursor tracking,
// control codes, and full-screen / single-row blanking.
//
// state      | meaning
// CLEAR_ALL  | blanking every cell, row-major from address 0
// IDLE       | accepting bytes, one per cycle
// CLEAR_LINE | blanking the row the cursor just entered
module text_console_writer
  import console_pkg::*;
(
  input  logic              in_main_clock,
  input  logic              in_reset,
  input  logic              in_char_valid,
  input  logic [7:0]        in_char_data,
  output logic              out_char_ready,
  output logic [ADDR_W-1:0] out_wr_address,
  output logic [7:0]        out_wr_data,
  output logic              out_wr_enable,
  output logic [COL_W-1:0]  out_cursor_x,
  output logic [ROW_W-1:0]  out_cursor_y,
  output logic              out_busy
);

  console_state_t    state;
  logic [COL_W-1:0]  cur_x;
  logic [ROW_W-1:0]  cur_y;
  logic [COL_W-1:0]  clr_col;
  logic [ROW_W-1:0]  clr_row;

  logic [COL_W-1:0]  calc_col;
  logic [ROW_W-1:0]  calc_row;
  logic [ADDR_W-1:0] calc_addr;
  logic [ROW_W-1:0]  next_row;
  logic              accept;
  logic              is_print;

  assign out_char_ready = (state == IDLE);
  assign out_busy       = ~out_char_ready;
  assign out_cursor_x   = cur_x;
  assign out_cursor_y   = cur_y;

  assign accept   = in_char_valid & out_char_ready;
  assign is_print = (in_char_data >= PRINT_LO) && (in_char_data <= PRINT_HI);
  assign next_row = (cur_y == LAST_ROW) ? '0 : cur_y + ROW_W'(1);

  // One calculator serves both paths; a clear line has already moved cur_y to the new row.
  always_comb begin
    calc_col = clr_col;
    calc_row = cur_y;
    if (state == IDLE)
      calc_col = (in_char_data == CC_BS) ? cur_x - COL_W'(1) : cur_x;
    if (state == CLEAR_ALL)
      calc_row = clr_row;
  end

  console_addr_calc u_addr_calc (
    .col  (calc_col),
    .row  (calc_row),
    .addr (calc_addr)
  );

  always_ff @(posedge in_main_clock or posedge in_reset) begin
    if (in_reset) begin
      state          <= CLEAR_ALL;
      cur_x          <= '0;
      cur_y          <= '0;
      clr_col        <= '0;
      clr_row        <= '0;
      out_wr_enable  <= 1'b0;
      out_wr_address <= '0;
      out_wr_data    <= '0;
    end else begin
      out_wr_enable <= 1'b0;
      case (state)
        CLEAR_ALL: begin
          out_wr_enable  <= 1'b1;
          out_wr_address <= calc_addr;
          out_wr_data    <= BLANK_CHAR;
          if (clr_col == LAST_COL) begin
            clr_col <= '0;
            if (clr_row == LAST_ROW) begin
              clr_row <= '0;
              state   <= IDLE;
            end else begin
              clr_row <= clr_row + ROW_W'(1);
            end
          end else begin
            clr_col <= clr_col + COL_W'(1);
          end
        end

        CLEAR_LINE: begin
          out_wr_enable  <= 1'b1;
          out_wr_address <= calc_addr;
          out_wr_data    <= BLANK_CHAR;
          if (clr_col == LAST_COL) begin
            clr_col <= '0;
            state   <= IDLE;
          end else begin
            clr_col <= clr_col + COL_W'(1);
          end
        end

        IDLE: begin
          if (accept) begin
            if (is_print) begin
              out_wr_enable  <= 1'b1;
              out_wr_address <= calc_addr;
              out_wr_data    <= in_char_data;
              if (cur_x == LAST_COL) begin
                cur_x <= '0;
                cur_y <= next_row;
                state <= CLEAR_LINE;
              end else begin
                cur_x <= cur_x + COL_W'(1);
              end
            end else begin
              case (in_char_data)
                CC_CR: cur_x <= '0;
                CC_LF: begin
                  cur_y <= next_row;
                  state <= CLEAR_LINE;
                end
                CC_BS: begin
                  if (cur_x != '0) begin
                    cur_x          <= cur_x - COL_W'(1);
                    out_wr_enable  <= 1'b1;
                    out_wr_address <= calc_addr;
                    out_wr_data    <= BLANK_CHAR;
                  end
                end
                CC_FF: begin
                  cur_x <= '0;
                  cur_y <= '0;
                  state <= CLEAR_ALL;
                end
                default: ;
              endcase
            end
          end
        end

        default: state <= CLEAR_ALL;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: reset clear, printing, wrap, control codes,
// form feed and reset during a row clear.
module tb_text_console_writer;
  import console_pkg::*;

  logic              main_clock = 1'b0;
  logic              rst;
  logic              valid;
  logic [7:0]        data;
  logic              ready;
  logic [ADDR_W-1:0] wr_address;
  logic [7:0]        wr_data;
  logic              wr_enable;
  logic [5:0]        cursor_x;
  logic [4:0]        cursor_y;
  logic              busy;

  int total = 0;
  int bad   = 0;

  always #5 main_clock = ~main_clock;

  text_console_writer dut (
    .in_main_clock  (main_clock),
    .in_reset       (rst),
    .in_char_valid  (valid),
    .in_char_data   (data),
    .out_char_ready (ready),
    .out_wr_address (wr_address),
    .out_wr_data    (wr_data),
    .out_wr_enable  (wr_enable),
    .out_cursor_x   (cursor_x),
    .out_cursor_y   (cursor_y),
    .out_busy       (busy)
  );

  task automatic tick();
    @(posedge main_clock);
    #1;
  endtask

  // Waits (bounded) for ready, presents one byte for exactly one edge.
  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    while (ready !== 1'b1 && w < 3000) begin
      tick();
      w++;
    end
    if (ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL send_wait got ready=%b want ready=1", ready);
    end
    valid = 1'b1;
    data  = b;
    tick();
    valid = 1'b0;
    data  = 8'h00;
  endtask

  // Follows a clear until ready rises, counting blank writes and sequence errors.
  task automatic collect_clear(input int base, output int n, output int seq_err, output int cycles);
    int exp_a = base;
    n = 0;
    seq_err = 0;
    cycles = 0;
    while (cycles < 1400) begin
      tick();
      cycles++;
      if (wr_enable === 1'b1) begin
        if (wr_address !== ADDR_W'(exp_a) || wr_data !== 8'h20) seq_err++;
        exp_a++;
        n++;
      end
      if (ready === 1'b1) break;
    end
  endtask

  task automatic newline_drain();
    int n, s, c;
    send_byte(CC_LF);
    collect_clear(0, n, s, c);
  endtask

  task automatic test_reset();
    int n, s, c;
    rst = 1'b1;
    valid = 1'b0;
    data = 8'h00;
    repeat (3) tick();
    total++;
    if (wr_enable !== 1'b0 || wr_address !== 11'd0 || wr_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_wr got we=%b addr=%0d data=%h want 0/0/00", wr_enable, wr_address, wr_data);
    end
    total++;
    if (ready !== 1'b0 || busy !== 1'b1 || cursor_x !== 6'd0 || cursor_y !== 5'd0) begin
      bad++;
      $display("FAIL reset_state got ready=%b busy=%b cur=(%0d,%0d) want 0/1/(0,0)", ready, busy, cursor_x, cursor_y);
    end
    rst = 1'b0;
    collect_clear(0, n, s, c);
    total++;
    if (n !== 1280 || s !== 0) begin
      bad++;
      $display("FAIL reset_clear got writes=%0d seq_err=%0d want 1280/0", n, s);
    end
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || cursor_x !== 6'd0 || cursor_y !== 5'd0) begin
      bad++;
      $display("FAIL reset_idle got ready=%b busy=%b cur=(%0d,%0d) want 1/0/(0,0)", ready, busy, cursor_x, cursor_y);
    end
    tick();
    total++;
    if (wr_enable !== 1'b0) begin
      bad++;
      $display("FAIL reset_clear_end got we=%b want 0", wr_enable);
    end
  endtask

  task automatic test_print();
    send_byte(8'h41);
    total++;
    if (wr_enable !== 1'b1 || wr_address !== 11'd0 || wr_data !== 8'h41 || cursor_x !== 6'd1 || cursor_y !== 5'd0) begin
      bad++;
      $display("FAIL print_A got we=%b addr=%0d data=%h cur=(%0d,%0d) want 1/0/41/(1,0)", wr_enable, wr_address, wr_data, cursor_x, cursor_y);
    end
    send_byte(8'h7F);
    total++;
    if (wr_enable !== 1'b0 || cursor_x !== 6'd1 || cursor_y !== 5'd0) begin
      bad++;
      $display("FAIL ignore_7F got we=%b cur=(%0d,%0d) want 0/(1,0)", wr_enable, cursor_x, cursor_y);
    end
    send_byte(CC_CR);
    total++;
    if (wr_enable !== 1'b0 || cursor_x !== 6'd0 || cursor_y !== 5'd0) begin
      bad++;
      $display("FAIL cr_home got we=%b cur=(%0d,%0d) want 0/(0,0)", wr_enable, cursor_x, cursor_y);
    end
  endtask

  task automatic test_back_to_back();
    int n, s, c;
    valid = 1'b1;
    data  = 8'h42;
    for (int i = 0; i < 40; i++) begin
      tick();
      total++;
      if (wr_enable !== 1'b1 || wr_address !== ADDR_W'(i) || wr_data !== 8'h42) begin
        bad++;
        $display("FAIL b2b_write[%0d] got we=%b addr=%0d data=%h want 1/%0d/42", i, wr_enable, wr_address, wr_data, i);
      end
    end
    valid = 1'b0;
    data  = 8'h00;
    total++;
    if (ready !== 1'b0 || cursor_x !== 6'd0 || cursor_y !== 5'd1) begin
      bad++;
      $display("FAIL b2b_wrap got ready=%b cur=(%0d,%0d) want 0/(0,1)", ready, cursor_x, cursor_y);
    end
    collect_clear(40, n, s, c);
    total++;
    if (n !== 40 || s !== 0 || c !== 40) begin
      bad++;
      $display("FAIL b2b_line_clear got writes=%0d seq_err=%0d cycles=%0d want 40/0/40", n, s, c);
    end
  endtask

  task automatic test_backspace();
    newline_drain();
    newline_drain();
    repeat (5) send_byte(8'h78);
    send_byte(CC_BS);
    total++;
    if (wr_enable !== 1'b1 || wr_address !== 11'd124 || wr_data !== 8'h20 || cursor_x !== 6'd4 || cursor_y !== 5'd3) begin
      bad++;
      $display("FAIL bs_mid got we=%b addr=%0d data=%h cur=(%0d,%0d) want 1/124/20/(4,3)", wr_enable, wr_address, wr_data, cursor_x, cursor_y);
    end
    repeat (3) send_byte(8'h79);
    send_byte(CC_CR);
    total++;
    if (wr_enable !== 1'b0 || cursor_x !== 6'd0 || cursor_y !== 5'd3) begin
      bad++;
      $display("FAIL cr_at_7 got we=%b cur=(%0d,%0d) want 0/(0,3)", wr_enable, cursor_x, cursor_y);
    end
    send_byte(CC_BS);
    total++;
    if (wr_enable !== 1'b0 || cursor_x !== 6'd0 || cursor_y !== 5'd3) begin
      bad++;
      $display("FAIL bs_at_0 got we=%b cur=(%0d,%0d) want 0/(0,3)", wr_enable, cursor_x, cursor_y);
    end
  endtask

  task automatic test_row_wrap();
    int n, s, c;
    repeat (28) newline_drain();
    repeat (12) send_byte(8'h7A);
    total++;
    if (cursor_x !== 6'd12 || cursor_y !== 5'd31) begin
      bad++;
      $display("FAIL wrap_setup got cur=(%0d,%0d) want (12,31)", cursor_x, cursor_y);
    end
    send_byte(CC_LF);
    total++;
    if (wr_enable !== 1'b0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL lf_accept got we=%b ready=%b want 0/0", wr_enable, ready);
    end
    collect_clear(0, n, s, c);
    total++;
    if (n !== 40 || s !== 0 || c !== 40 || cursor_x !== 6'd12 || cursor_y !== 5'd0) begin
      bad++;
      $display("FAIL lf_wrap got writes=%0d seq_err=%0d cycles=%0d cur=(%0d,%0d) want 40/0/40/(12,0)", n, s, c, cursor_x, cursor_y);
    end
  endtask

  task automatic test_form_feed();
    int n, s, c;
    send_byte(CC_CR);
    repeat (9) newline_drain();
    repeat (9) send_byte(8'h30);
    total++;
    if (cursor_x !== 6'd9 || cursor_y !== 5'd9) begin
      bad++;
      $display("FAIL ff_setup got cur=(%0d,%0d) want (9,9)", cursor_x, cursor_y);
    end
    send_byte(CC_FF);
    total++;
    if (wr_enable !== 1'b0 || ready !== 1'b0 || busy !== 1'b1 || cursor_x !== 6'd0 || cursor_y !== 5'd0) begin
      bad++;
      $display("FAIL ff_accept got we=%b ready=%b busy=%b cur=(%0d,%0d) want 0/0/1/(0,0)", wr_enable, ready, busy, cursor_x, cursor_y);
    end
    collect_clear(0, n, s, c);
    total++;
    if (n !== 1280 || s !== 0 || c !== 1280) begin
      bad++;
      $display("FAIL ff_clear got writes=%0d seq_err=%0d cycles=%0d want 1280/0/1280", n, s, c);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n, s, c;
    send_byte(8'h31);
    send_byte(CC_LF);
    repeat (5) tick();
    total++;
    if (wr_enable !== 1'b1 || wr_address !== 11'd44) begin
      bad++;
      $display("FAIL mid_clear got we=%b addr=%0d want 1/44", wr_enable, wr_address);
    end
    rst = 1'b1;
    #1;
    total++;
    if (wr_enable !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL async_reset got we=%b busy=%b want 0/1", wr_enable, busy);
    end
    tick();
    tick();
    rst = 1'b0;
    collect_clear(0, n, s, c);
    total++;
    if (n !== 1280 || s !== 0 || cursor_x !== 6'd0 || cursor_y !== 5'd0) begin
      bad++;
      $display("FAIL restart_clear got writes=%0d seq_err=%0d cur=(%0d,%0d) want 1280/0/(0,0)", n, s, cursor_x, cursor_y);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_print();
    test_back_to_back();
    test_backspace();
    test_row_wrap();
    test_form_feed();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
